// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the TLP transceiver: action records, error codes and header field extraction.
package tlp_xcvr_pkg;

  localparam int unsigned CHAN_BITS = 4;
  localparam logic [6:0]  FMT_MRD32 = 7'h00;
  localparam logic [6:0]  FMT_MWR32 = 7'h40;

  typedef enum logic [1:0] {ACT_WRITE = 2'd0, ACT_READ = 2'd1, ACT_ERROR = 2'd2} ActionType;
  typedef enum logic [1:0] {ERR_TYPE, ERR_LEN, ERR_BE, ERR_FRAMING} ErrorCode;

  typedef logic [CHAN_BITS-1:0] chan_t;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    chan_t       chan;
  } RegRead;

  typedef struct packed {
    chan_t       chan;
    logic [31:0] data;
  } RegWrite;

  // Only the view selected by typ is meaningful; the others are zero.
  typedef struct packed {
    ActionType typ;
    RegRead    rd;
    RegWrite   wr;
    ErrorCode  err;
  } Action;

  typedef struct packed {
    logic [6:0]  fmt_type;
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  first_be;
  } hdr_t;

  function automatic hdr_t hdr_decode(input logic [63:0] qw0);
    hdr_t h;
    h.fmt_type = qw0[30:24];
    h.len      = qw0[9:0];
    h.req_id   = qw0[63:48];
    h.tag      = qw0[47:40];
    h.first_be = qw0[35:32];
    return h;
  endfunction

  function automatic chan_t addr_chan(input logic [31:0] addr);
    return addr[CHAN_BITS+1:2];
  endfunction

  function automatic Action mk_read(input logic [15:0] req_id, input logic [7:0] tag,
                                    input chan_t chan);
    Action a;
    a           = '0;
    a.typ       = ACT_READ;
    a.rd.req_id = req_id;
    a.rd.tag    = tag;
    a.rd.chan   = chan;
    return a;
  endfunction

  function automatic Action mk_write(input chan_t chan, input logic [31:0] data);
    Action a;
    a         = '0;
    a.typ     = ACT_WRITE;
    a.wr.chan = chan;
    a.wr.data = data;
    return a;
  endfunction

  function automatic Action mk_error(input ErrorCode code);
    Action a;
    a     = '0;
    a.typ = ACT_ERROR;
    a.err = code;
    return a;
  endfunction

endpackage

// File: rtl/tlp_recv.sv
// TLP receive parser: turns 64-bit Avalon-ST TLP beats into one action record per TLP,
// held in a single-entry output register.
module tlp_recv
  import tlp_xcvr_pkg::*;
#(
  parameter bit CHECK_BE = 1'b1
) (
  input  logic        pcieClk_in,
  input  logic        pcieRst_in,
  input  logic [63:0] rxData_in,
  input  logic        rxValid_in,
  output logic        rxReady_out,
  input  logic        rxSOP_in,
  input  logic        rxEOP_in,
  output Action       actData_out,
  output logic        actValid_out,
  input  logic        actReady_in,
  output logic [31:0] errCount_out
);

  typedef enum logic [1:0] {S_IDLE, S_HDR1, S_DATA, S_DRAIN} state_e;

  state_e      state_q, state_d;
  hdr_t        hdr_q, hdr_d;
  chan_t       chan_q, chan_d;
  Action       act_q, act_d, act_new;
  logic        act_valid_q, act_valid_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic        beat, emit, finish;

  // A completing beat may load while the previous action is popped in the same cycle.
  assign rxReady_out = !pcieRst_in && (!act_valid_q || actReady_in);
  assign beat        = rxValid_in && rxReady_out;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    chan_d  = chan_q;
    emit    = 1'b0;
    finish  = 1'b0;
    act_new = '0;
    if (beat) begin
      if (rxSOP_in && state_q != S_IDLE) begin
        // Abandon the open TLP; the new SOP beat becomes the next header.
        emit    = 1'b1;
        act_new = mk_error(ERR_FRAMING);
        if (rxEOP_in) begin
          state_d = S_IDLE;
        end else begin
          hdr_d   = hdr_decode(rxData_in);
          state_d = S_HDR1;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (!rxSOP_in || rxEOP_in) begin
              emit    = 1'b1;
              finish  = 1'b1;
              act_new = mk_error(ERR_FRAMING);
            end else begin
              hdr_d   = hdr_decode(rxData_in);
              state_d = S_HDR1;
            end
          end
          S_HDR1: begin
            emit   = 1'b1;
            finish = 1'b1;
            if (hdr_q.fmt_type != FMT_MRD32 && hdr_q.fmt_type != FMT_MWR32) begin
              act_new = mk_error(ERR_TYPE);
            end else if (hdr_q.len != 10'd1) begin
              act_new = mk_error(ERR_LEN);
            end else if (CHECK_BE && hdr_q.first_be != 4'hF) begin
              act_new = mk_error(ERR_BE);
            end else if (hdr_q.fmt_type == FMT_MRD32) begin
              act_new = mk_read(hdr_q.req_id, hdr_q.tag, addr_chan(rxData_in[31:0]));
            end else if (rxData_in[2]) begin
              act_new = mk_write(addr_chan(rxData_in[31:0]), rxData_in[63:32]);
            end else if (rxEOP_in) begin
              act_new = mk_error(ERR_FRAMING);
            end else begin
              // QW-aligned write: data arrives in the low DW of the next beat.
              emit    = 1'b0;
              finish  = 1'b0;
              chan_d  = addr_chan(rxData_in[31:0]);
              state_d = S_DATA;
            end
          end
          S_DATA: begin
            emit    = 1'b1;
            finish  = 1'b1;
            act_new = mk_write(chan_q, rxData_in[31:0]);
          end
          S_DRAIN: begin
            if (rxEOP_in) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      if (finish) state_d = rxEOP_in ? S_IDLE : S_DRAIN;
    end
  end

  always_comb begin
    act_valid_d = act_valid_q && !actReady_in;
    act_d       = act_q;
    err_cnt_d   = err_cnt_q;
    if (emit) begin
      act_valid_d = 1'b1;
      act_d       = act_new;
      if (act_new.typ == ACT_ERROR && err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      chan_q      <= '0;
      act_q       <= '0;
      act_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      chan_q      <= chan_d;
      act_q       <= act_d;
      act_valid_q <= act_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign actData_out  = act_q;
  assign actValid_out = act_valid_q;
  assign errCount_out = err_cnt_q;

endmodule

// File: tb/tb_tlp_recv.sv
// Self-checking bench for tlp_recv: directed vector table, hand-written corner sequences and
// randomized TLP streams checked against a TLP-level reference model.
module tb_tlp_recv;
  import tlp_xcvr_pkg::*;

  logic        clk;
  logic        rst;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_sop;
  logic        rx_eop;
  Action       act_data;
  logic        act_valid;
  logic        act_ready;
  logic [31:0] err_count;

  logic rand_ready;
  logic rnd_ready;
  logic ready_force;
  assign act_ready = rand_ready ? rnd_ready : ready_force;

  tlp_recv #(.CHECK_BE(1'b1)) dut (
    .pcieClk_in  (clk),
    .pcieRst_in  (rst),
    .rxData_in   (rx_data),
    .rxValid_in  (rx_valid),
    .rxReady_out (rx_ready),
    .rxSOP_in    (rx_sop),
    .rxEOP_in    (rx_eop),
    .actData_out (act_data),
    .actValid_out(act_valid),
    .actReady_in (act_ready),
    .errCount_out(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  Action got[$];
  Action expq[$];
  int    tests = 0;
  int    fails = 0;
  int    exp_err = 0;

  always @(negedge clk) begin
    if (!rst && act_valid && act_ready) got.push_back(act_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  function automatic Action e_wr(input logic [3:0] c, input logic [31:0] d);
    Action a;
    a = '0; a.typ = ACT_WRITE; a.wr.chan = c; a.wr.data = d;
    return a;
  endfunction

  function automatic Action e_rd(input logic [15:0] r, input logic [7:0] t, input logic [3:0] c);
    Action a;
    a = '0; a.typ = ACT_READ; a.rd.req_id = r; a.rd.tag = t; a.rd.chan = c;
    return a;
  endfunction

  function automatic Action e_err(input ErrorCode e);
    Action a;
    a = '0; a.typ = ACT_ERROR; a.err = e;
    return a;
  endfunction

  function automatic logic [63:0] mkhdr(input logic [6:0] ft, input logic [9:0] len,
                                        input logic [15:0] rid, input logic [7:0] tag,
                                        input logic [3:0] be);
    return {rid, tag, 4'h0, be, 1'b0, ft, 14'h0, len};
  endfunction

  // Only the fields relevant to the action type are compared.
  function automatic logic [63:0] view(input Action a);
    case (a.typ)
      ACT_WRITE: return 64'({a.typ, a.wr.chan, a.wr.data});
      ACT_READ:  return 64'({a.typ, a.rd.req_id, a.rd.tag, a.rd.chan});
      default:   return 64'({a.typ, a.err});
    endcase
  endfunction

  // Whole-TLP reference: which action does a well-delimited TLP of n beats produce.
  function automatic Action model(input bit sop0, input int n, input logic [63:0] q0,
                                  input logic [63:0] q1, input logic [63:0] q2);
    logic [6:0]  ft;
    logic [31:0] addr;
    ft   = q0[30:24];
    addr = q1[31:0];
    if (!sop0 || n < 2) return e_err(ERR_FRAMING);
    if (ft != 7'h00 && ft != 7'h40) return e_err(ERR_TYPE);
    if (q0[9:0] != 10'd1) return e_err(ERR_LEN);
    if (q0[35:32] != 4'hF) return e_err(ERR_BE);
    if (ft == 7'h00) return e_rd(q0[63:48], q0[47:40], addr[5:2]);
    if (addr[2]) return e_wr(addr[5:2], q1[63:32]);
    if (n < 3) return e_err(ERR_FRAMING);
    return e_wr(addr[5:2], q2[31:0]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_act(input string name, input Action a, input Action e);
    check(name, view(a), view(e));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input bit sop, input bit eop);
    bit acc;
    rx_data  = d;
    rx_sop   = sop;
    rx_eop   = eop;
    rx_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = rx_ready;
      cycle();
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL beat_accept: got no ready expected ready within 300 cycles");
    end
  endtask

  task automatic send_tlp(input bit sop0, input int n, input logic [63:0] q0,
                          input logic [63:0] q1, input logic [63:0] q2, input logic [63:0] q3);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? q0 : (i == 1) ? q1 : (i == 2) ? q2 : q3;
      send_beat(d, (i == 0) && sop0, i == n - 1);
    end
    rx_valid = 1'b0;
  endtask

  task automatic expect_action(input string name, input Action e);
    for (int i = 0; i < 20 && got.size() == 0; i++) cycle();
    if (e.typ == ACT_ERROR) exp_err++;
    if (got.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no action expected %h", name, view(e));
    end else begin
      check_act(name, got.pop_front(), e);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_err = 0;
  endtask

  typedef struct {
    string       name;
    bit          sop0;
    int          n;
    logic [63:0] q0, q1, q2, q3;
    Action       exp;
    bit          chk_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input bit sop0, input int n, input logic [63:0] q0,
                     input logic [63:0] q1, input logic [63:0] q2, input Action e,
                     input bit lat);
    vec_t v;
    v.name = name; v.sop0 = sop0; v.n = n;
    v.q0 = q0; v.q1 = q1; v.q2 = q2; v.q3 = 64'h5555_AAAA_5555_AAAA;
    v.exp = e; v.chk_lat = lat;
    vecs.push_back(v);
  endtask

  logic [6:0] odd_types[4];

  initial begin
    logic [63:0] q0, q1, q2, q3;
    logic [6:0]  ft;
    logic [9:0]  len;
    logic [3:0]  be;
    logic [31:0] addr;
    bit          sop0;
    int          n;
    Action       e;

    odd_types = '{7'h20, 7'h60, 7'h4A, 7'h0A};

    add("wr_hi", 1, 2, mkhdr(7'h40, 1, 0, 0, 4'hF), {32'hCAFEBABE, 32'h14}, 0,
        e_wr(4'd5, 32'hCAFEBABE), 1);
    add("wr_lo", 1, 3, mkhdr(7'h40, 1, 0, 0, 4'hF), {32'hDEADDEAD, 32'h10},
        {32'h0, 32'h12345678}, e_wr(4'd4, 32'h12345678), 1);
    add("rd", 1, 2, mkhdr(7'h00, 1, 16'h0100, 8'h07, 4'hF), {32'h0, 32'h08}, 0,
        e_rd(16'h0100, 8'h07, 4'd2), 1);
    add("len2", 1, 4, mkhdr(7'h40, 2, 0, 0, 4'hF), {32'h11111111, 32'h14}, 64'h1, e_err(ERR_LEN),
        0);
    add("cpl", 1, 2, mkhdr(7'h0A, 1, 0, 0, 4'hF), {32'h1, 32'h14}, 0, e_err(ERR_TYPE), 1);
    add("be", 1, 2, mkhdr(7'h40, 1, 0, 0, 4'h3), {32'h1, 32'h14}, 0, e_err(ERR_BE), 1);
    add("type_over_len", 1, 2, mkhdr(7'h20, 3, 0, 0, 4'h0), {32'h1, 32'h14}, 0, e_err(ERR_TYPE),
        1);
    add("len_over_be", 1, 2, mkhdr(7'h00, 0, 0, 0, 4'h0), {32'h1, 32'h14}, 0, e_err(ERR_LEN), 1);
    add("stray", 0, 1, 64'h0123_4567_89AB_CDEF, 0, 0, e_err(ERR_FRAMING), 1);
    add("rd_after_stray", 1, 2, mkhdr(7'h00, 1, 16'hBEEF, 8'hA5, 4'hF), {32'h0, 32'h3C}, 0,
        e_rd(16'hBEEF, 8'hA5, 4'd15), 1);
    add("sop_eop", 1, 1, mkhdr(7'h00, 1, 0, 0, 4'hF), 0, 0, e_err(ERR_FRAMING), 1);
    add("wr_short", 1, 2, mkhdr(7'h40, 1, 0, 0, 4'hF), {32'h9, 32'h10}, 0, e_err(ERR_FRAMING), 1);
    add("rd_excess", 1, 3, mkhdr(7'h00, 1, 16'h1234, 8'h01, 4'hF), {32'h0, 32'h44}, 64'h7,
        e_rd(16'h1234, 8'h01, 4'd1), 0);
    add("wr_hi_ch15", 1, 2, mkhdr(7'h40, 1, 0, 0, 4'hF), {32'h0BADF00D, 32'hFFFF_FFFC}, 0,
        e_wr(4'd15, 32'h0BADF00D), 1);

    rst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = '0;
    rand_ready = 1'b0; ready_force = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_act_valid", 64'(act_valid), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      send_tlp(vecs[i].sop0, vecs[i].n, vecs[i].q0, vecs[i].q1, vecs[i].q2, vecs[i].q3);
      if (vecs[i].chk_lat) check({vecs[i].name, "_latency"}, 64'(act_valid), 64'd1);
      expect_action(vecs[i].name, vecs[i].exp);
    end
    repeat (3) cycle();
    check("table_no_extra", 64'(got.size()), 64'd0);
    check("table_err_count", 64'(err_count), 64'(exp_err));

    // Backpressure: held action stays put and blocks input until popped.
    ready_force = 1'b0;
    send_tlp(1, 2, mkhdr(7'h00, 1, 16'h0100, 8'h07, 4'hF), {32'h0, 32'h08}, 0, 0);
    rx_data = mkhdr(7'h40, 1, 0, 0, 4'hF); rx_sop = 1'b1; rx_eop = 1'b0; rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rx_ready", 64'(rx_ready), 64'd0);
      check("bp_valid", 64'(act_valid), 64'd1);
      check_act("bp_stable", act_data, e_rd(16'h0100, 8'h07, 4'd2));
      cycle();
    end
    ready_force = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(rx_ready), 64'd1);
    cycle();
    send_beat({32'hFACE_0001, 32'h14}, 0, 1);
    rx_valid = 1'b0;
    expect_action("bp_read", e_rd(16'h0100, 8'h07, 4'd2));
    expect_action("bp_next_write", e_wr(4'd5, 32'hFACE_0001));

    // SOP inside an open TLP: framing error, then the new TLP parses normally.
    send_beat(mkhdr(7'h40, 1, 0, 0, 4'hF), 1, 0);
    send_beat(mkhdr(7'h00, 1, 16'h0042, 8'h03, 4'hF), 1, 0);
    send_beat({32'h0, 32'h08}, 0, 1);
    rx_valid = 1'b0;
    expect_action("sop_mid_framing", e_err(ERR_FRAMING));
    expect_action("sop_mid_read", e_rd(16'h0042, 8'h03, 4'd2));

    // Reset drops a pending action.
    ready_force = 1'b0;
    send_tlp(1, 2, mkhdr(7'h00, 1, 16'h0007, 8'h09, 4'hF), {32'h0, 32'h0C}, 0, 0);
    pulse_reset();
    check("rst_drop_valid", 64'(act_valid), 64'd0);
    check("rst_err_cleared", 64'(err_count), 64'd0);
    ready_force = 1'b1;
    repeat (3) cycle();
    check("rst_drop_none", 64'(got.size()), 64'd0);

    // Reset inside S_DATA: trailing data beat becomes a framing error, no write.
    send_beat(mkhdr(7'h40, 1, 0, 0, 4'hF), 1, 0);
    send_beat({32'h0, 32'h10}, 0, 0);
    rx_valid = 1'b0;
    pulse_reset();
    check("rst_data_valid", 64'(act_valid), 64'd0);
    send_beat({32'h0, 32'h7777_7777}, 0, 1);
    rx_valid = 1'b0;
    expect_action("rst_data_framing", e_err(ERR_FRAMING));
    send_tlp(1, 2, mkhdr(7'h00, 1, 16'h0100, 8'h07, 4'hF), {32'h0, 32'h08}, 0, 0);
    expect_action("rst_then_read", e_rd(16'h0100, 8'h07, 4'd2));
    check("rst_err_count", 64'(err_count), 64'd1);

    // Randomized TLP stream with random downstream backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        sop0 = 0; n = 1;
        q0 = {$urandom, $urandom}; q1 = '0; q2 = '0;
      end else begin
        sop0 = 1;
        n = $urandom_range(1, 4);
        case ($urandom_range(0, 7))
          0, 1, 2: ft = 7'h00;
          3, 4, 5: ft = 7'h40;
          6:       ft = odd_types[$urandom_range(0, 3)];
          default: ft = 7'($urandom);
        endcase
        len  = ($urandom_range(0, 4) == 0) ? 10'($urandom) : 10'd1;
        be   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
        addr = $urandom;
        q0 = mkhdr(ft, len, 16'($urandom), 8'($urandom), be);
        q1 = {$urandom, addr};
        q2 = {$urandom, $urandom};
      end
      q3 = {$urandom, $urandom};
      e = model(sop0, n, q0, q1, q2);
      if (e.typ == ACT_ERROR) exp_err++;
      expq.push_back(e);
      send_tlp(sop0, n, q0, q1, q2, q3);
      repeat ($urandom_range(0, 2)) cycle();
    end
    for (int i = 0; i < 400 && got.size() < expq.size(); i++) cycle();
    check("rnd_count", 64'(got.size()), 64'(expq.size()));
    for (int i = 0; got.size() > 0 && expq.size() > 0; i++) begin
      check_act($sformatf("rnd_%0d", i), got.pop_front(), expq.pop_front());
    end
    check("rnd_err_count", 64'(err_count), 64'(exp_err));
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
